// File: rtl/fpu_mul_opstage.sv
// rtl/fpu_mul_opstage.sv - classifying operand FIFO ahead of the FP multiplier
// Optional macro FPU_MUL_OPSTAGE_FLUSH_SUBNORM_EN: flush subnormal operands to signed zero.

package ibex_pkg;
   typedef enum logic [3:0] {
      NaN, Inf, Neg_Inf, Pos_Zero, Neg_Zero,
      Pos_Subnorm, Neg_Subnorm, Pos_Norm, Neg_Norm
   } Classif_e;
endpackage

module fpu_mul_opstage #(
   parameter int unsigned DEPTH = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      flush_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [31:0]               in_rs1_i,
   input  logic [31:0]               in_rs2_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [31:0]               out_rs1_o,
   output logic [31:0]               out_rs2_o,
   output ibex_pkg::Classif_e        out_classif_a_o,
   output ibex_pkg::Classif_e        out_classif_b_o,
   output logic                      out_special_o,
   output logic [$clog2(DEPTH):0]    occupancy_o
);
   import ibex_pkg::*;

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   function automatic Classif_e classify(input logic [31:0] v);
      logic [7:0]  exp_f;
      logic [22:0] mant_f;
      exp_f  = v[30:23];
      mant_f = v[22:0];
      if (exp_f == 8'hFF) begin
         if (mant_f != '0) return NaN;
         return v[31] ? Neg_Inf : Inf;
      end
      if (exp_f == 8'h00) begin
         if (mant_f == '0) return v[31] ? Neg_Zero : Pos_Zero;
`ifdef FPU_MUL_OPSTAGE_FLUSH_SUBNORM_EN
         return v[31] ? Neg_Zero : Pos_Zero;
`else
         return v[31] ? Neg_Subnorm : Pos_Subnorm;
`endif
      end
      return v[31] ? Neg_Norm : Pos_Norm;
   endfunction

   function automatic logic [31:0] sanitize(input logic [31:0] v);
`ifdef FPU_MUL_OPSTAGE_FLUSH_SUBNORM_EN
      if (v[30:23] == 8'h00) return {v[31], 31'b0};
`endif
      return v;
   endfunction

   function automatic logic is_special(input Classif_e c);
      return (c == NaN) || (c == Inf) || (c == Neg_Inf) ||
             (c == Pos_Zero) || (c == Neg_Zero);
   endfunction

   logic [31:0] r_rs1_mem [DEPTH];
   logic [31:0] r_rs2_mem [DEPTH];
   Classif_e    r_cla_mem [DEPTH];
   Classif_e    r_clb_mem [DEPTH];

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic w_push;
   logic w_pop;

   assign in_ready_o  = (r_count != CW'(DEPTH));
   assign out_valid_o = (r_count != '0);
   assign w_push      = in_valid_i & in_ready_o;
   assign w_pop       = out_valid_o & out_ready_i;

   // Flush and reset share the same clear path; flush also drops any same-cycle push.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_ni && !flush_i && w_push) begin
         r_rs1_mem[r_wr_ptr] <= sanitize(in_rs1_i);
         r_rs2_mem[r_wr_ptr] <= sanitize(in_rs2_i);
         r_cla_mem[r_wr_ptr] <= classify(in_rs1_i);
         r_clb_mem[r_wr_ptr] <= classify(in_rs2_i);
      end
   end

   assign out_rs1_o       = r_rs1_mem[r_rd_ptr];
   assign out_rs2_o       = r_rs2_mem[r_rd_ptr];
   assign out_classif_a_o = r_cla_mem[r_rd_ptr];
   assign out_classif_b_o = r_clb_mem[r_rd_ptr];
   assign out_special_o   = out_valid_o &
                            (is_special(r_cla_mem[r_rd_ptr]) | is_special(r_clb_mem[r_rd_ptr]));
   assign occupancy_o     = r_count;

endmodule

// File: tb/tb_fpu_mul_opstage.sv
// tb/tb_fpu_mul_opstage.sv - directed-vector bench for fpu_mul_opstage

module tb_fpu_mul_opstage;
   import ibex_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        flush_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] in_rs1_i;
   logic [31:0] in_rs2_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_rs1_o;
   logic [31:0] out_rs2_o;
   Classif_e    out_classif_a_o;
   Classif_e    out_classif_b_o;
   logic        out_special_o;
   logic [1:0]  occupancy_o;

   int n_chk  = 0;
   int n_pass = 0;

   fpu_mul_opstage #(.DEPTH(2)) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .flush_i         (flush_i),
      .in_valid_i      (in_valid_i),
      .in_ready_o      (in_ready_o),
      .in_rs1_i        (in_rs1_i),
      .in_rs2_i        (in_rs2_i),
      .out_valid_o     (out_valid_o),
      .out_ready_i     (out_ready_i),
      .out_rs1_o       (out_rs1_o),
      .out_rs2_o       (out_rs2_o),
      .out_classif_a_o (out_classif_a_o),
      .out_classif_b_o (out_classif_b_o),
      .out_special_o   (out_special_o),
      .occupancy_o     (occupancy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic check_empty(input string tag);
      check({tag, ".valid"},   32'(out_valid_o),   32'd0);
      check({tag, ".ready"},   32'(in_ready_o),    32'd1);
      check({tag, ".occ"},     32'(occupancy_o),   32'd0);
      check({tag, ".special"}, 32'(out_special_o), 32'd0);
   endtask

   logic [31:0] stream_a [10];
   logic [31:0] stream_b [10];

   initial begin
      rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
      in_rs1_i = '0; in_rs2_i = '0;
      @(negedge clk_i);
      step();
      check_empty("reset");
      rst_ni = 1'b1;
      step();

      // normal pair
      in_valid_i = 1'b1; in_rs1_i = 32'h3FC00000; in_rs2_i = 32'h40000000;
      step();
      in_valid_i = 1'b0;
      check("norm.valid",   32'(out_valid_o),     32'd1);
      check("norm.cla",     32'(out_classif_a_o), 32'(Pos_Norm));
      check("norm.clb",     32'(out_classif_b_o), 32'(Pos_Norm));
      check("norm.special", 32'(out_special_o),   32'd0);
      check("norm.occ",     32'(occupancy_o),     32'd1);
      check("norm.rs1",     out_rs1_o,            32'h3FC00000);
      out_ready_i = 1'b1;
      step();
      out_ready_i = 1'b0;
      check_empty("norm.pop");

      // NaN / -Inf pair
      in_valid_i = 1'b1; in_rs1_i = 32'h7FC00000; in_rs2_i = 32'hFF800000;
      step();
      in_valid_i = 1'b0;
      check("nan.cla",     32'(out_classif_a_o), 32'(NaN));
      check("nan.clb",     32'(out_classif_b_o), 32'(Neg_Inf));
      check("nan.special", 32'(out_special_o),   32'd1);
      out_ready_i = 1'b1;
      step();
      out_ready_i = 1'b0;
      check_empty("nan.pop");

      // fill to full with consumer stalled
      in_valid_i = 1'b1; in_rs1_i = 32'h3F800000; in_rs2_i = 32'h40400000;
      step();
      in_rs1_i = 32'hBF800000; in_rs2_i = 32'h40800000;
      step();
      in_rs1_i = 32'h41000000; in_rs2_i = 32'h41100000;
      check("full.ready", 32'(in_ready_o),  32'd0);
      check("full.occ",   32'(occupancy_o), 32'd2);
      step();
      check("stall.occ",  32'(occupancy_o), 32'd2);
      check("stall.rs1",  out_rs1_o,        32'h3F800000);
      check("stall.rs2",  out_rs2_o,        32'h40400000);

      // flush while full with a pair on offer
      flush_i = 1'b1;
      step();
      flush_i = 1'b0; in_valid_i = 1'b0;
      check_empty("flush");
      step();
      check("flush.hold.occ", 32'(occupancy_o), 32'd0);

      // streaming across pointer wrap
      for (int k = 0; k < 10; k++) begin
         stream_a[k] = 32'h3F800000 + 32'(k) * 32'h00100000;
         stream_b[k] = 32'hC0000000 + 32'(k) * 32'h00010000;
      end
      out_ready_i = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_valid_i = 1'b1; in_rs1_i = stream_a[k]; in_rs2_i = stream_b[k];
         step();
         check($sformatf("stream%0d.rs1", k), out_rs1_o,         stream_a[k]);
         check($sformatf("stream%0d.rs2", k), out_rs2_o,         stream_b[k]);
         check($sformatf("stream%0d.occ", k), 32'(occupancy_o),  32'd1);
      end
      in_valid_i = 1'b0;
      step();
      out_ready_i = 1'b0;
      check_empty("stream.drain");

      // subnormal handling
      in_valid_i = 1'b1; in_rs1_i = 32'h00000001; in_rs2_i = 32'h80000003;
      step();
      in_valid_i = 1'b0;
`ifdef FPU_MUL_OPSTAGE_FLUSH_SUBNORM_EN
      check("sub.rs1",     out_rs1_o,                 32'h00000000);
      check("sub.rs2",     out_rs2_o,                 32'h80000000);
      check("sub.cla",     32'(out_classif_a_o),      32'(Pos_Zero));
      check("sub.clb",     32'(out_classif_b_o),      32'(Neg_Zero));
      check("sub.special", 32'(out_special_o),        32'd1);
`else
      check("sub.rs1",     out_rs1_o,                 32'h00000001);
      check("sub.rs2",     out_rs2_o,                 32'h80000003);
      check("sub.cla",     32'(out_classif_a_o),      32'(Pos_Subnorm));
      check("sub.clb",     32'(out_classif_b_o),      32'(Neg_Subnorm));
      check("sub.special", 32'(out_special_o),        32'd0);
`endif

      // reset mid-operation discards queued entries
      in_valid_i = 1'b1; in_rs1_i = 32'h3F800000; in_rs2_i = 32'h3F800000;
      step();
      in_valid_i = 1'b0;
      check("prereset.occ", 32'(occupancy_o), 32'd2);
      rst_ni = 1'b0; out_ready_i = 1'b1;
      step();
      rst_ni = 1'b1; out_ready_i = 1'b0;
      check_empty("midreset");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
